// File: rtl/wf_mask_table_40x64b.sv
// rtl/wf_mask_table_40x64b.sv - per-wavefront 64-bit exec mask store, 40 slots
// Dispatch init, masked write-back and retire ports; 1-cycle registered read port with bypass.
module wf_mask_table_40x64b #(
  parameter int NUM_WF = 40,
  parameter int DATA_W = 64,
  parameter int WFID_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init_en,
  input  logic [WFID_W-1:0]        init_wfid,
  input  logic [DATA_W-1:0]        init_data,
  input  logic                     wr_en,
  input  logic [WFID_W-1:0]        wr_wfid,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W-1:0]        wr_bitmask,
  input  logic                     retire_en,
  input  logic [WFID_W-1:0]        retire_wfid,
  input  logic                     rd_req,
  input  logic [WFID_W-1:0]        rd_wfid,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [NUM_WF*DATA_W-1:0] entries_flat,
  output logic [NUM_WF-1:0]        entry_valid,
  output logic                     err
);

  localparam logic [WFID_W-1:0] NUM_ID = WFID_W'(NUM_WF);

  logic [NUM_WF*DATA_W-1:0] ent_q, ent_nxt;
  logic [NUM_WF-1:0]        vld_q, vld_nxt;
  logic [DATA_W-1:0]        rd_mux;
  logic                     init_in, wr_in, retire_in, rd_in;
  logic                     wr_tgt_vld, wr_shadowed, err_nxt;

  assign init_in   = init_en   && (init_wfid   < NUM_ID);
  assign wr_in     = wr_en     && (wr_wfid     < NUM_ID);
  assign retire_in = retire_en && (retire_wfid < NUM_ID);
  assign rd_in     = rd_req    && (rd_wfid     < NUM_ID);

  // A write hidden behind a same-slot retire or init is dropped silently.
  assign wr_shadowed = (init_in && (init_wfid == wr_wfid)) ||
                       (retire_in && (retire_wfid == wr_wfid));

  always_comb begin
    ent_nxt    = ent_q;
    vld_nxt    = vld_q;
    wr_tgt_vld = 1'b0;
    for (int i = 0; i < NUM_WF; i++) begin
      if (wr_in && (wr_wfid == WFID_W'(i))) begin
        wr_tgt_vld = vld_q[i];
      end
      if (retire_in && (retire_wfid == WFID_W'(i))) begin
        ent_nxt[i*DATA_W +: DATA_W] = '0;
        vld_nxt[i]                  = 1'b0;
      end else if (init_in && (init_wfid == WFID_W'(i))) begin
        ent_nxt[i*DATA_W +: DATA_W] = init_data;
        vld_nxt[i]                  = 1'b1;
      end else if (wr_in && (wr_wfid == WFID_W'(i)) && vld_q[i]) begin
        ent_nxt[i*DATA_W +: DATA_W] = (ent_q[i*DATA_W +: DATA_W] & ~wr_bitmask) |
                                      (wr_data & wr_bitmask);
      end
    end
  end

  // Read sees this cycle's committed updates; out-of-range ids read as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_WF; i++) begin
      if (rd_in && (rd_wfid == WFID_W'(i))) begin
        rd_mux = ent_nxt[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    err_nxt = (init_en   && !init_in)   ||
              (wr_en     && !wr_in)     ||
              (retire_en && !retire_in) ||
              (rd_req    && !rd_in)     ||
              (wr_in && !wr_tgt_vld && !wr_shadowed);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q    <= '0;
      vld_q    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      ent_q    <= ent_nxt;
      vld_q    <= vld_nxt;
      rd_valid <= rd_req;
      err      <= err_nxt;
      if (rd_req) begin
        rd_data <= rd_mux;
      end
    end
  end

  assign entries_flat = ent_q;
  assign entry_valid  = vld_q;

endmodule

// File: doc/wf_mask_table_40x64b.md
Name: wf_mask_table_40x64b

Overview:
Per-wavefront 64-bit mask store (exec mask per wavefront slot) for 40 wavefront slots. It feeds the 40:1 64-bit wavefront-select mux through a flat 2560-bit bus. It also provides its own registered read port with a valid strobe, used by issue-side consumers. Wavefronts are initialised at dispatch, updated by write-back with a per-bit enable, and cleared at retire.

Parameters:
NUM_WF, 40, number of wavefront slots
DATA_W, 64, mask width per slot
WFID_W, 6, wavefront id width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
init_en  input  1  load slot at wavefront dispatch
init_wfid  input  6  slot to initialise
init_data  input  64  initial mask
wr_en  input  1  masked update of a slot
wr_wfid  input  6  slot to update
wr_data  input  64  new bits
wr_bitmask  input  64  per-bit write enable
retire_en  input  1  invalidate slot at wavefront end
retire_wfid  input  6  slot to retire
rd_req  input  1  read request
rd_wfid  input  6  slot to read
rd_data  output  64  registered read data
rd_valid  output  1  one-cycle strobe, rd_data is valid
entries_flat  output  2560  slot i occupies bits [64*i+63 : 64*i], registered
entry_valid  output  40  per-slot valid bits
err  output  1  one-cycle strobe, illegal access in the previous cycle

Behaviour:
- Reset (rst=1 at a clk edge):
  - All entries are set to 0 and entry_valid to 0.
  - rd_data, rd_valid and err are set to 0.
  - Any in-flight read is dropped, so rd_valid=0 on the cycle after reset.
- Init: on init_en with init_wfid<40, the entry becomes init_data and valid becomes 1. Init is legal on an already-valid slot and overwrites it.
- Write: on wr_en with wr_wfid<40 and the slot valid, the entry becomes (old & ~wr_bitmask) | (wr_data & wr_bitmask).
- Retire: on retire_en with retire_wfid<40, valid becomes 0 and the entry becomes 0.
- All three ports apply in the same cycle when they target distinct slots.
- Same-slot priority: retire > init > write. A lower-priority op on that slot is discarded without error.
- Read:
  - Latency is 1 cycle. rd_req at edge N gives rd_valid=1 and rd_data at edge N+1.
  - rd_data reflects the slot value after all updates committed at edge N (write-through bypass). It is equivalent to sampling entries_flat one cycle later.
  - rd_valid=0 when no request is made; rd_data holds its last value.
  - Back-to-back reads are supported every cycle.
- Reading a non-valid slot returns its stored value (0). This is not an error.
- Errors: err=1 on the cycle after any of the following:
  - any enabled port presents a wfid of 40..63;
  - wr_en targets a non-valid slot that is not being initialised in the same cycle.
- Effects of illegal accesses:
  - An illegal op has no state effect.
  - An illegal read still returns rd_valid=1 with rd_data=0.
  - A write discarded by priority does not raise err.
- entries_flat and entry_valid are driven directly from the storage flops. Updates committed at edge N are visible immediately after edge N.

Test Plan:
- Reset, then init slot 5 with 64'hFFFF_FFFF_FFFF_FFFF -> entry_valid[5]=1; entries_flat[383:320]=all ones; all other slots 0.
- Slot 5 all ones; wr_data=0, wr_bitmask=64'h0000_0000_0000_00FF; rd_req slot 5 in the same cycle -> next cycle rd_valid=1, rd_data=64'hFFFF_FFFF_FFFF_FF00.
- Same cycle: retire slot 39, init slot 39 with 64'h1, wr slot 39 -> slot 39 valid=0, entries_flat[2559:2496]=0, err=0.
- wr_en to never-initialised slot 10; then rd_req with rd_wfid=45 -> err=1 after each op; slot 10 stays 0; rd_valid=1 with rd_data=0.
- Init slot 0 and slot 1 in consecutive cycles with 64'hA and 64'hB, then issue rd_req for slots 0,1,0 back-to-back -> rd_data 64'hA, 64'hB, 64'hA on three consecutive cycles.
- Issue rd_req on the same edge that rst=1 -> rd_valid=0 on the following cycle; all entries 0.
